encap_stage_seq: RTL
====================

# encap_stage_seq

Parametrised frame-stage sequencer for the Ethernet MAC encapsulation path. It walks one transmit frame through IDLE, PREAMBLE, SFD, HEADER, PAYLOAD, FCS and IFG, one byte per qualifying strobe. It drives a one-hot stage vector and a per-stage byte counter, and computes minimum-frame padding. Downstream byte muxes (preamble generator, header/payload source, CRC output) select on stage_o and byte_cnt_o.

## Interface
Parameters:
- PREAMBLE_LEN, 7: preamble bytes (0x55), must be ≥1
- HDR_LEN, 14: DA+SA+EtherType bytes
- MIN_PAYLOAD, 46: minimum payload bytes; shorter payloads are padded
- MAX_PAYLOAD, 1500: maximum payload bytes; longer requests are clamped
- FCS_LEN, 4: FCS bytes
- IFG_LEN, 12: inter-frame gap bytes, must be ≥1
- LEN_W, 11: width of len_i and byte_cnt_o; must hold MAX_PAYLOAD

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-low reset
- start_i  in  1  frame request; accepted only in IDLE
- len_i  in  LEN_W  requested payload length in bytes; sampled with start_i
- adv_i  in  1  byte strobe from the PHY side; one byte consumed per high cycle
- abort_i  in  1  truncate the current frame
- stage_o  out  7  one-hot stage: bit0 IDLE, 1 PREAMBLE, 2 SFD, 3 HEADER, 4 PAYLOAD, 5 FCS, 6 IFG
- byte_cnt_o  out  LEN_W  byte index within the current stage
- last_o  out  1  current byte is the last of its stage
- pad_o  out  1  current PAYLOAD byte is padding
- busy_o  out  1  stage is not IDLE
- done_o  out  1  one-cycle pulse on return to IDLE
- len_err_o  out  1  len_i exceeded MAX_PAYLOAD and was clamped; sticky until the next accepted start
- aborted_o  out  1  the current or last frame was aborted; sticky until the next accepted start

## Operation
- Reset (rst=0 at a clk edge):
  - stage_o = 7'b0000001, byte_cnt_o = 0.
  - last_o, pad_o, busy_o, done_o, len_err_o, aborted_o all 0.
  - Reset overrides every other input, in any stage.
- FSM states map one-to-one to the stage_o bits. Exactly one bit is high at all times.
- Stage byte counts N:
  - PREAMBLE_LEN, 1, HDR_LEN, plen, FCS_LEN, IFG_LEN.
  - plen = min(max(len_i, MIN_PAYLOAD), MAX_PAYLOAD), latched at start.
- IDLE, start_i=1:
  - Latch plen and the raw length, clamped to MAX_PAYLOAD, as dlen.
  - Go to PREAMBLE with byte_cnt 0.
  - len_err_o = (len_i > MAX_PAYLOAD); aborted_o = 0.
  - No adv_i is needed for this transition.
- IDLE, start_i=0: hold. adv_i and abort_i are ignored in IDLE.
- start_i while busy: ignored, with no side effects.
- Non-IDLE stage, adv_i=1:
  - If byte_cnt == N−1, go to the next stage with byte_cnt = 0.
  - Otherwise byte_cnt increments.
  - Leaving IFG returns to IDLE and asserts done_o for exactly one cycle.
- Non-IDLE stage, adv_i=0: stage and count hold.
- abort_i=1 in HEADER or PAYLOAD:
  - Go to IFG with byte_cnt 0 and set aborted_o.
  - Takes priority over adv_i. No FCS is sent.
- abort_i in PREAMBLE, SFD, FCS, IFG or IDLE: ignored.
- last_o = busy_o and (byte_cnt_o == N−1) for the current stage. Combinational from registered state.
- pad_o = stage PAYLOAD and (byte_cnt_o ≥ dlen). Combinational from registered state.
- Arithmetic:
  - Unsigned throughout.
  - Comparisons are at LEN_W bits; byte_cnt never exceeds N−1.
  - len_i = 0 is legal and gives plen = MIN_PAYLOAD, all padded.

## Timing
- All state is registered on the rising clk edge.
- Output latency:
  - stage_o and byte_cnt_o reflect an adv_i or abort_i sampled at edge k from k+1.
  - start_i sampled at edge k gives stage_o = PREAMBLE from k+1.
- done_o is high in the first IDLE cycle after the final IFG adv.
  - A start_i in that same cycle is accepted, giving back-to-back frames separated only by the IFG.
- With adv_i held high, one frame occupies PREAMBLE_LEN+1+HDR_LEN+plen+FCS_LEN+IFG_LEN cycles of busy_o. For the defaults with plen = 46, that is 84 cycles.
- Reset asserted mid-frame: IDLE on the next edge, no done_o pulse.

## Test plan
- Reset values: hold rst=0 for 3 cycles with adv_i=1 and start_i=1 → stage_o=0000001, byte_cnt_o=0, all flags 0.
- Nominal frame:
  - Stimulus: start_i with len_i=100, adv_i always high.
  - Required: stage sequence with counts 7,1,14,100,4,12; busy_o high for 138 cycles; pad_o never high; done_o a single pulse; last_o once per stage.
- Short frame padding:
  - Stimulus: len_i=10.
  - Required: PAYLOAD lasts 46 cycles; pad_o low for byte_cnt 0–9 and high for 10–45.
  - Stimulus: len_i=0.
  - Required: pad_o high for all 46 bytes.
- Clamp:
  - Stimulus: len_i=1600.
  - Required: PAYLOAD lasts 1500 cycles; len_err_o=1 until the next start; next start with len_i=60 clears it.
- Stall and abort:
  - Stimulus: drop adv_i for 5 cycles mid-HEADER.
  - Required: stage and count frozen during the stall.
  - Stimulus: assert abort_i at PAYLOAD byte 20.
  - Required: next cycle is IFG with cnt 0; aborted_o=1; no FCS; done_o after 12 advs.
- Back-to-back and reset mid-frame:
  - Stimulus: start_i in the done_o cycle.
  - Required: PREAMBLE on the next cycle.
  - Stimulus: rst=0 at PAYLOAD byte 5.
  - Required: IDLE next cycle; done_o stays 0; a start_i during busy is ignored.

Source files
------------

// File: rtl/encap_stage_seq_if.sv
// Frame-stage sequencer bus.
// master: frame request side (start, len, adv, abort) that reads back stage/status.
// slave:  the sequencer, which drives stage, byte_cnt and the status flags.
interface encap_stage_seq_if #(
  parameter int LEN_W = 11
);
  logic             start;
  logic [LEN_W-1:0] len;
  logic             adv;
  logic             abort;
  logic [6:0]       stage;
  logic [LEN_W-1:0] byte_cnt;
  logic             last;
  logic             pad;
  logic             busy;
  logic             done;
  logic             len_err;
  logic             aborted;

  modport master (
    output start, len, adv, abort,
    input  stage, byte_cnt, last, pad, busy, done, len_err, aborted
  );

  modport slave (
    input  start, len, adv, abort,
    output stage, byte_cnt, last, pad, busy, done, len_err, aborted
  );
endinterface

// File: rtl/encap_stage_seq.sv
// Ethernet MAC encapsulation frame-stage sequencer.
// Walks one frame through IDLE, PREAMBLE, SFD, HEADER, PAYLOAD, FCS, IFG,
// one byte per adv strobe, and reports the one-hot stage, the byte index
// within the stage, last/pad qualifiers and sticky len_err/aborted flags.
// Ports:
//   clk  - clock
//   rst  - synchronous, active-low reset
//   bus  - slave modport of encap_stage_seq_if (start/len/adv/abort in,
//          stage/byte_cnt/last/pad/busy/done/len_err/aborted out)
//
// state    | meaning
// ---------+-------------------------------------------
// S_IDLE   | no frame; waits for start
// S_PRE    | preamble bytes (PREAMBLE_LEN)
// S_SFD    | start-of-frame delimiter (1 byte)
// S_HDR    | DA+SA+EtherType (HDR_LEN)
// S_PAY    | payload incl. padding (plen)
// S_FCS    | frame check sequence (FCS_LEN)
// S_IFG    | inter-frame gap (IFG_LEN)
module encap_stage_seq #(
  parameter int PREAMBLE_LEN = 7,
  parameter int HDR_LEN      = 14,
  parameter int MIN_PAYLOAD  = 46,
  parameter int MAX_PAYLOAD  = 1500,
  parameter int FCS_LEN      = 4,
  parameter int IFG_LEN      = 12,
  parameter int LEN_W        = 11
) (
  input logic              clk,
  input logic              rst,
  encap_stage_seq_if.slave bus
);

  // State encoding equals the stage bit, so stage can be driven straight
  // from the state register.
  typedef enum logic [6:0] {
    S_IDLE = 7'b0000001,
    S_PRE  = 7'b0000010,
    S_SFD  = 7'b0000100,
    S_HDR  = 7'b0001000,
    S_PAY  = 7'b0010000,
    S_FCS  = 7'b0100000,
    S_IFG  = 7'b1000000
  } state_t;

  localparam logic [LEN_W-1:0] PRE_N = LEN_W'(PREAMBLE_LEN);
  localparam logic [LEN_W-1:0] HDR_N = LEN_W'(HDR_LEN);
  localparam logic [LEN_W-1:0] MIN_N = LEN_W'(MIN_PAYLOAD);
  localparam logic [LEN_W-1:0] MAX_N = LEN_W'(MAX_PAYLOAD);
  localparam logic [LEN_W-1:0] FCS_N = LEN_W'(FCS_LEN);
  localparam logic [LEN_W-1:0] IFG_N = LEN_W'(IFG_LEN);
  localparam logic [LEN_W-1:0] ONE   = LEN_W'(1);

  state_t           state, state_n;
  logic [LEN_W-1:0] cnt, cnt_n;
  logic [LEN_W-1:0] plen, plen_n;
  logic [LEN_W-1:0] dlen, dlen_n;
  logic             len_err, len_err_n;
  logic             aborted, aborted_n;
  logic             done, done_n;

  logic [LEN_W-1:0] stage_len;
  logic             last_hit;
  logic [LEN_W-1:0] req_dlen;
  logic [LEN_W-1:0] req_plen;
  state_t           next_stage;

  // Requested length clamped to MAX (data bytes) and then raised to MIN
  // (bytes actually sent in PAYLOAD).
  assign req_dlen = (bus.len > MAX_N) ? MAX_N : bus.len;
  assign req_plen = (req_dlen < MIN_N) ? MIN_N : req_dlen;

  always_comb begin
    stage_len  = ONE;
    next_stage = S_IDLE;
    unique case (state)
      S_PRE:   begin stage_len = PRE_N; next_stage = S_SFD; end
      S_SFD:   begin stage_len = ONE;   next_stage = S_HDR; end
      S_HDR:   begin stage_len = HDR_N; next_stage = S_PAY; end
      S_PAY:   begin stage_len = plen;  next_stage = S_FCS; end
      S_FCS:   begin stage_len = FCS_N; next_stage = S_IFG; end
      S_IFG:   begin stage_len = IFG_N; next_stage = S_IDLE; end
      default: begin stage_len = ONE;   next_stage = S_IDLE; end
    endcase
  end

  assign last_hit = (cnt == stage_len - ONE);

  always_ff @(posedge clk) begin
    if (!rst) begin
      state   <= S_IDLE;
      cnt     <= '0;
      plen    <= MIN_N;
      dlen    <= '0;
      len_err <= 1'b0;
      aborted <= 1'b0;
      done    <= 1'b0;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      plen    <= plen_n;
      dlen    <= dlen_n;
      len_err <= len_err_n;
      aborted <= aborted_n;
      done    <= done_n;
    end
  end

  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    plen_n    = plen;
    dlen_n    = dlen;
    len_err_n = len_err;
    aborted_n = aborted;
    done_n    = 1'b0;

    if (state == S_IDLE) begin
      if (bus.start) begin
        state_n   = S_PRE;
        cnt_n     = '0;
        plen_n    = req_plen;
        dlen_n    = req_dlen;
        len_err_n = (bus.len > MAX_N);
        aborted_n = 1'b0;
      end
    end else if (bus.abort && (state == S_HDR || state == S_PAY)) begin
      // Truncation skips FCS entirely; the gap is still honoured.
      state_n   = S_IFG;
      cnt_n     = '0;
      aborted_n = 1'b1;
    end else if (bus.adv) begin
      if (last_hit) begin
        state_n = next_stage;
        cnt_n   = '0;
        done_n  = (state == S_IFG);
      end else begin
        cnt_n = cnt + ONE;
      end
    end
  end

  assign bus.stage    = state;
  assign bus.byte_cnt = cnt;
  assign bus.busy     = (state != S_IDLE);
  assign bus.last     = (state != S_IDLE) && last_hit;
  assign bus.pad      = (state == S_PAY) && (cnt >= dlen);
  assign bus.done     = done;
  assign bus.len_err  = len_err;
  assign bus.aborted  = aborted;

endmodule
